writeback: RTL and testbench

- Final pipeline stage; consumes the per-instruction bundle registered by the memory stage.
- Selects the destination-register write data and drives the register-file write port and the CSR-unit write port.
- Retires instructions and counts them (instret).
- Converts exceptions, interrupts, mret and wfi into trap and redirect pulses for the CSR unit and fetch. Holds the pipeline in a sleep state while a wfi waits for an interrupt.

---
 rtl/writeback.sv | 124 ++++++++++++
 tb/tb_writeback.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage: selects register-file write data, retires instructions,
// and turns exceptions, interrupts, mret and wfi into trap/redirect pulses.
module writeback #(
    parameter int          INSTRET_WIDTH = 64,
    parameter logic [31:0] RESET_PC      = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc_in,
    input  logic [31:0]              next_pc_in,
    input  logic [31:0]              alu_data_in,
    input  logic [31:0]              csr_data_in,
    input  logic [31:0]              load_data_in,
    input  logic [1:0]               write_select_in,
    input  logic [4:0]               rd_address_in,
    input  logic [11:0]              csr_address_in,
    input  logic                     mret_in,
    input  logic                     wfi_in,
    input  logic                     valid_in,
    input  logic [3:0]               ecause_in,
    input  logic                     exception_in,
    input  logic                     interrupt_pending,
    input  logic [3:0]               interrupt_cause,
    output logic                     rd_write,
    output logic [4:0]               rd_address,
    output logic [31:0]              rd_data,
    output logic                     csr_write,
    output logic [11:0]              csr_address,
    output logic [31:0]              csr_data,
    output logic                     trap,
    output logic                     trap_interrupt,
    output logic [3:0]               trap_cause,
    output logic [31:0]              trap_pc,
    output logic                     mret,
    output logic                     stall_request,
    output logic                     retired,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] SLEEP = 1'b1;

    logic [0:0]  state;
    logic [31:0] wake_pc;
    logic        take_int;
    logic        take_exc;
    logic        commit;
    logic        wake;
    logic [31:0] mux_data;

    // An interrupt pre-empts the instruction entirely, so it blocks commit too.
    always_comb begin
        take_int = (state == RUN) && valid_in && interrupt_pending;
        take_exc = (state == RUN) && valid_in && exception_in && !take_int;
        commit   = (state == RUN) && valid_in && !exception_in && !take_int;
        wake     = (state == SLEEP) && interrupt_pending;
    end

    always_comb begin
        case (write_select_in)
            2'b00:   mux_data = alu_data_in;
            2'b01:   mux_data = csr_data_in;
            2'b10:   mux_data = load_data_in;
            default: mux_data = next_pc_in;
        endcase
    end

    // Every output is forced low while reset is held.
    always_comb begin
        rd_write       = 1'b0;
        rd_address     = 5'd0;
        rd_data        = 32'd0;
        csr_write      = 1'b0;
        csr_address    = 12'd0;
        csr_data       = 32'd0;
        trap           = 1'b0;
        trap_interrupt = 1'b0;
        trap_cause     = 4'd0;
        trap_pc        = 32'd0;
        mret           = 1'b0;
        stall_request  = 1'b0;
        retired        = 1'b0;
        if (!reset) begin
            rd_write    = commit && (rd_address_in != 5'd0);
            rd_address  = rd_address_in;
            rd_data     = mux_data;
            csr_write   = commit && (csr_address_in != 12'd0);
            csr_address = csr_address_in;
            csr_data    = alu_data_in;
            mret        = commit && mret_in;
            retired     = commit;
            stall_request = (state == SLEEP) && !interrupt_pending;
            if (take_int || wake) begin
                trap           = 1'b1;
                trap_interrupt = 1'b1;
                trap_cause     = interrupt_cause;
                trap_pc        = wake ? wake_pc : pc_in;
            end else if (take_exc) begin
                trap       = 1'b1;
                trap_cause = ecause_in;
                trap_pc    = pc_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            instret <= '0;
            wake_pc <= RESET_PC;
        end else begin
            if (commit) begin
                instret <= instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
            end
            if (commit && wfi_in && !interrupt_pending) begin
                state   <= SLEEP;
                wake_pc <= next_pc_in;
            end else if (wake) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed vector table, wfi/reset/wrap
// sequences, and randomized traffic against a behavioural model.
module tb_writeback;

    localparam int IW = 8;

    logic          clk;
    logic          reset;
    logic [31:0]   pc_in, next_pc_in, alu_data_in, csr_data_in, load_data_in;
    logic [1:0]    write_select_in;
    logic [4:0]    rd_address_in;
    logic [11:0]   csr_address_in;
    logic          mret_in, wfi_in, valid_in, exception_in, interrupt_pending;
    logic [3:0]    ecause_in, interrupt_cause;
    logic          rd_write, csr_write, trap, trap_interrupt, mret, stall_request, retired;
    logic [4:0]    rd_address;
    logic [31:0]   rd_data, csr_data, trap_pc;
    logic [11:0]   csr_address;
    logic [3:0]    trap_cause;
    logic [IW-1:0] instret;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    bit          mdl_sleep;
    int          mdl_count;
    logic [31:0] mdl_wake_pc;

    writeback #(.INSTRET_WIDTH(IW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .alu_data_in(alu_data_in), .csr_data_in(csr_data_in), .load_data_in(load_data_in),
        .write_select_in(write_select_in), .rd_address_in(rd_address_in),
        .csr_address_in(csr_address_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .valid_in(valid_in), .ecause_in(ecause_in), .exception_in(exception_in),
        .interrupt_pending(interrupt_pending), .interrupt_cause(interrupt_cause),
        .rd_write(rd_write), .rd_address(rd_address), .rd_data(rd_data),
        .csr_write(csr_write), .csr_address(csr_address), .csr_data(csr_data),
        .trap(trap), .trap_interrupt(trap_interrupt), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .mret(mret), .stall_request(stall_request),
        .retired(retired), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc, alu, csr, load;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [11:0] csra;
        logic        mret_i, wfi_i, exc;
        logic [3:0]  ecause;
        logic        irq;
        logic [3:0]  icause;
        logic        e_rdw;
        logic [31:0] e_rdd;
        logic        e_csrw, e_trap, e_tint;
        logic [3:0]  e_tcause;
        logic [31:0] e_tpc;
        logic        e_mret, e_ret;
    } vec_t;

    typedef struct {
        logic        rdw;
        logic [31:0] rdd;
        logic        csrw, trap, tint;
        logic [3:0]  tcause;
        logic [31:0] tpc;
        logic        mret, ret, stall;
    } exp_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        valid_in        = v.valid;
        pc_in           = v.pc;
        next_pc_in      = v.pc + 32'd4;
        alu_data_in     = v.alu;
        csr_data_in     = v.csr;
        load_data_in    = v.load;
        write_select_in = v.sel;
        rd_address_in   = v.rd;
        csr_address_in  = v.csra;
        mret_in         = v.mret_i;
        wfi_in          = v.wfi_i;
        exception_in    = v.exc;
        ecause_in       = v.ecause;
        interrupt_pending = v.irq;
        interrupt_cause = v.icause;
    endtask

    function automatic exp_t modelOutputs();
        exp_t e;
        e = '{default: '0};
        case (write_select_in)
            2'd0: e.rdd = alu_data_in;
            2'd1: e.rdd = csr_data_in;
            2'd2: e.rdd = load_data_in;
            default: e.rdd = next_pc_in;
        endcase
        if (mdl_sleep) begin
            if (interrupt_pending) begin
                e.trap = 1; e.tint = 1; e.tcause = interrupt_cause; e.tpc = mdl_wake_pc;
            end else begin
                e.stall = 1;
            end
        end else if (valid_in) begin
            if (interrupt_pending) begin
                e.trap = 1; e.tint = 1; e.tcause = interrupt_cause; e.tpc = pc_in;
            end else if (exception_in) begin
                e.trap = 1; e.tcause = ecause_in; e.tpc = pc_in;
            end else begin
                e.ret  = 1;
                e.rdw  = (rd_address_in != 0);
                e.csrw = (csr_address_in != 0);
                e.mret = mret_in;
            end
        end
        return e;
    endfunction

    task automatic checkModel(input string tag);
        exp_t e;
        e = modelOutputs();
        checkOutput({tag, ".rd_write"}, 64'(rd_write), 64'(e.rdw));
        checkOutput({tag, ".rd_address"}, 64'(rd_address), 64'(rd_address_in));
        checkOutput({tag, ".rd_data"}, 64'(rd_data), 64'(e.rdd));
        checkOutput({tag, ".csr_write"}, 64'(csr_write), 64'(e.csrw));
        checkOutput({tag, ".csr_data"}, 64'(csr_data), 64'(alu_data_in));
        checkOutput({tag, ".trap"}, 64'(trap), 64'(e.trap));
        checkOutput({tag, ".trap_interrupt"}, 64'(trap_interrupt), 64'(e.tint));
        checkOutput({tag, ".trap_cause"}, 64'(trap_cause), 64'(e.tcause));
        checkOutput({tag, ".trap_pc"}, 64'(trap_pc), 64'(e.tpc));
        checkOutput({tag, ".mret"}, 64'(mret), 64'(e.mret));
        checkOutput({tag, ".retired"}, 64'(retired), 64'(e.ret));
        checkOutput({tag, ".stall"}, 64'(stall_request), 64'(e.stall));
        checkOutput({tag, ".instret"}, 64'(instret), 64'(mdl_count));
    endtask

    // Advance one clock: the model consumes the inputs seen at the edge.
    task automatic clockModel();
        exp_t e;
        @(posedge clk);
        e = modelOutputs();
        if (e.ret) mdl_count = (mdl_count + 1) % (1 << IW);
        if (!mdl_sleep && e.ret && wfi_in) begin
            mdl_sleep = 1;
            mdl_wake_pc = next_pc_in;
        end else if (mdl_sleep && interrupt_pending) begin
            mdl_sleep = 0;
        end
        @(negedge clk);
    endtask

    vec_t table_v[9];
    vec_t v;
    vec_t idle;

    initial begin
        idle = '{name: "idle", default: '0};
        table_v[0] = '{name:"alu_commit", valid:1, pc:32'h10, alu:32'h1234, csr:0, load:0, sel:0, rd:5, csra:0,
                       mret_i:0, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:1, e_rdd:32'h1234, e_csrw:0, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:0, e_ret:1};
        table_v[1] = '{name:"x0_csr", valid:1, pc:32'h14, alu:32'h80, csr:0, load:0, sel:0, rd:0, csra:12'h305,
                       mret_i:0, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:0, e_rdd:32'h80, e_csrw:1, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:0, e_ret:1};
        table_v[2] = '{name:"sel_csr", valid:1, pc:32'h18, alu:1, csr:32'hCAFE, load:2, sel:1, rd:3, csra:0,
                       mret_i:0, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:1, e_rdd:32'hCAFE, e_csrw:0, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:0, e_ret:1};
        table_v[3] = '{name:"sel_load", valid:1, pc:32'h1C, alu:1, csr:2, load:32'hBEEF, sel:2, rd:31, csra:0,
                       mret_i:0, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:1, e_rdd:32'hBEEF, e_csrw:0, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:0, e_ret:1};
        table_v[4] = '{name:"sel_link", valid:1, pc:32'h40, alu:1, csr:2, load:3, sel:3, rd:1, csra:0,
                       mret_i:0, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:1, e_rdd:32'h44, e_csrw:0, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:0, e_ret:1};
        table_v[5] = '{name:"exception", valid:1, pc:32'h100, alu:7, csr:0, load:0, sel:0, rd:5, csra:12'h305,
                       mret_i:0, wfi_i:0, exc:1, ecause:4, irq:0, icause:0,
                       e_rdw:0, e_rdd:7, e_csrw:0, e_trap:1, e_tint:0, e_tcause:4, e_tpc:32'h100, e_mret:0, e_ret:0};
        table_v[6] = '{name:"irq_over_exc", valid:1, pc:32'h200, alu:9, csr:0, load:0, sel:0, rd:5, csra:12'h305,
                       mret_i:1, wfi_i:0, exc:1, ecause:4, irq:1, icause:7,
                       e_rdw:0, e_rdd:9, e_csrw:0, e_trap:1, e_tint:1, e_tcause:7, e_tpc:32'h200, e_mret:0, e_ret:0};
        table_v[7] = '{name:"mret_commit", valid:1, pc:32'h60, alu:0, csr:0, load:0, sel:0, rd:0, csra:0,
                       mret_i:1, wfi_i:0, exc:0, ecause:0, irq:0, icause:0,
                       e_rdw:0, e_rdd:0, e_csrw:0, e_trap:0, e_tint:0, e_tcause:0, e_tpc:0, e_mret:1, e_ret:1};
        table_v[8] = '{name:"mret_exc", valid:1, pc:32'h64, alu:0, csr:0, load:0, sel:0, rd:0, csra:0,
                       mret_i:1, wfi_i:0, exc:1, ecause:2, irq:0, icause:0,
                       e_rdw:0, e_rdd:0, e_csrw:0, e_trap:1, e_tint:0, e_tcause:2, e_tpc:32'h64, e_mret:0, e_ret:0};

        // Reset state
        applyStimulus(table_v[0]);
        reset = 1'b1;
        mdl_sleep = 0; mdl_count = 0; mdl_wake_pc = 0;
        #2;
        checkOutput("reset.rd_write", 64'(rd_write), 64'd0);
        checkOutput("reset.retired", 64'(retired), 64'd0);
        checkOutput("reset.rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset.instret", 64'(instret), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        foreach (table_v[i]) begin
            v = table_v[i];
            applyStimulus(v);
            #2;
            checkOutput({v.name, ".rd_write"}, 64'(rd_write), 64'(v.e_rdw));
            checkOutput({v.name, ".rd_data"}, 64'(rd_data), 64'(v.e_rdd));
            checkOutput({v.name, ".csr_write"}, 64'(csr_write), 64'(v.e_csrw));
            checkOutput({v.name, ".csr_data"}, 64'(csr_data), 64'(v.alu));
            checkOutput({v.name, ".trap"}, 64'(trap), 64'(v.e_trap));
            checkOutput({v.name, ".trap_interrupt"}, 64'(trap_interrupt), 64'(v.e_tint));
            checkOutput({v.name, ".trap_cause"}, 64'(trap_cause), 64'(v.e_tcause));
            checkOutput({v.name, ".trap_pc"}, 64'(trap_pc), 64'(v.e_tpc));
            checkOutput({v.name, ".mret"}, 64'(mret), 64'(v.e_mret));
            checkOutput({v.name, ".retired"}, 64'(retired), 64'(v.e_ret));
            checkOutput({v.name, ".instret"}, 64'(instret), 64'(mdl_count));
            clockModel();
        end
        applyStimulus(idle);
        #2;
        checkOutput("table.instret_final", 64'(instret), 64'd6);

        // WFI sleep and wake
        v = table_v[0];
        v.pc = 32'h300; v.wfi_i = 1; v.rd = 0;
        applyStimulus(v);
        #2;
        checkOutput("wfi.retired", 64'(retired), 64'd1);
        checkOutput("wfi.stall_same_cycle", 64'(stall_request), 64'd0);
        clockModel();
        for (int i = 0; i < 10; i++) begin
            v = table_v[0];
            v.pc = 32'h500 + 32'(i * 4);
            applyStimulus(v);
            #2;
            checkOutput("sleep.stall", 64'(stall_request), 64'd1);
            checkOutput("sleep.rd_write", 64'(rd_write), 64'd0);
            checkOutput("sleep.retired", 64'(retired), 64'd0);
            checkOutput("sleep.trap", 64'(trap), 64'd0);
            clockModel();
        end
        applyStimulus(idle);
        interrupt_pending = 1'b1;
        interrupt_cause = 4'd3;
        #2;
        checkOutput("wake.trap", 64'(trap), 64'd1);
        checkOutput("wake.trap_interrupt", 64'(trap_interrupt), 64'd1);
        checkOutput("wake.trap_cause", 64'(trap_cause), 64'd3);
        checkOutput("wake.trap_pc", 64'(trap_pc), 64'h304);
        checkOutput("wake.stall", 64'(stall_request), 64'd0);
        clockModel();
        applyStimulus(idle);
        #2;
        checkOutput("wake.run_stall", 64'(stall_request), 64'd0);
        checkOutput("wake.instret", 64'(instret), 64'd7);
        clockModel();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            valid_in        = ($urandom_range(99) < 60);
            pc_in           = $urandom & 32'hFFFF_FFFC;
            next_pc_in      = pc_in + 32'd4;
            alu_data_in     = $urandom;
            csr_data_in     = $urandom;
            load_data_in    = $urandom;
            write_select_in = 2'($urandom_range(3));
            rd_address_in   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            csr_address_in  = ($urandom_range(1) == 0) ? 12'd0 : 12'($urandom);
            mret_in         = ($urandom_range(9) == 0);
            wfi_in          = ($urandom_range(9) == 0);
            exception_in    = ($urandom_range(99) < 15);
            ecause_in       = 4'($urandom);
            interrupt_pending = ($urandom_range(99) < 15);
            interrupt_cause = 4'($urandom);
            #2;
            checkModel("rand");
            clockModel();
        end

        // Counter wrap: commit until all-ones, then once more
        applyStimulus(idle);
        interrupt_pending = 1'b0;
        clockModel();
        while (mdl_sleep) begin
            interrupt_pending = 1'b1;
            clockModel();
            interrupt_pending = 1'b0;
        end
        v = table_v[0];
        for (int i = 0; i < 300 && mdl_count != (1 << IW) - 1; i++) begin
            applyStimulus(v);
            #2;
            checkModel("wrap_fill");
            clockModel();
        end
        applyStimulus(v);
        #2;
        checkOutput("wrap.all_ones", 64'(instret), 64'hFF);
        clockModel();
        applyStimulus(idle);
        #2;
        checkOutput("wrap.zero", 64'(instret), 64'd0);

        // Reset while sleeping
        v = table_v[0];
        v.wfi_i = 1;
        applyStimulus(v);
        clockModel();
        applyStimulus(idle);
        #2;
        checkOutput("rst_sleep.stall_before", 64'(stall_request), 64'd1);
        checkOutput("rst_sleep.instret_before", 64'(instret), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_sleep.stall", 64'(stall_request), 64'd0);
        checkOutput("rst_sleep.instret", 64'(instret), 64'd0);
        interrupt_pending = 1'b1;
        interrupt_cause = 4'd5;
        #1;
        checkOutput("rst_sleep.no_trap", 64'(trap), 64'd0);
        mdl_sleep = 0; mdl_count = 0;
        @(negedge clk);
        reset = 1'b0;
        interrupt_pending = 1'b0;
        #2;
        checkOutput("rst_sleep.run_stall", 64'(stall_request), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
